// File: rtl/iob_ram_sp_arb_if.sv
// Bus bundle between the requesters, the round-robin arbiter and one
// single-port RAM. The arbiter side is the slave modport; whoever drives
// the requests and models the RAM uses the master modport.
interface iob_ram_sp_arb_if #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 14
);
  // requester side
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        resp_rvalid;
  logic [DATA_W-1:0]       resp_rdata;

  // RAM side
  logic                    ram_en;
  logic                    ram_we;
  logic [ADDR_W-1:0]       ram_addr;
  logic [DATA_W-1:0]       ram_din;
  logic [DATA_W-1:0]       ram_dout;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ram_dout,
    output req_ready, resp_rvalid, resp_rdata,
           ram_en, ram_we, ram_addr, ram_din
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, ram_dout,
    input  req_ready, resp_rvalid, resp_rdata,
           ram_en, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/iob_ram_sp_arb.sv
// Round-robin arbiter in front of one single-port RAM with a 1-cycle
// registered read. Grant and RAM drive are combinational in the request
// cycle; the read strobe goes to the owner one cycle later, and read data
// is the RAM output passed straight through.
//
// There is no state machine here: the only state is the rotating priority
// pointer and the one-hot read-strobe register.
module iob_ram_sp_arb #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              arst_n,
  iob_ram_sp_arb_if.slave   bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] gnt_idx;
  logic             gnt_any;
  logic [N_REQ-1:0] grant;
  logic             gnt_we;
  logic [N_REQ-1:0] rvalid_q;
  logic [N_REQ-1:0] rvalid_d;

  // Scan from the pointer upward (wrapping) and grant the first valid requester.
  always_comb begin
    int idx;
    idx     = 0;
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = (int'(ptr_q) + off) % N_REQ;
      if (!gnt_any && bus.req_valid[idx]) begin
        gnt_any    = 1'b1;
        grant[idx] = 1'b1;
        gnt_idx    = PTR_W'(idx);
      end
    end
  end

  // Steer the granted requester onto the RAM port; an idle port is driven to zero.
  always_comb begin
    gnt_we       = 1'b0;
    bus.ram_addr = '0;
    bus.ram_din  = '0;
    if (gnt_any) begin
      gnt_we       = bus.req_we[gnt_idx];
      bus.ram_addr = bus.req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
      bus.ram_din  = bus.req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
    end
  end

  // Next pointer lands just past the winner so it drops to lowest priority.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      if (gnt_idx == PTR_W'(N_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx + PTR_W'(1);
      end
    end
  end

  // Only reads earn a strobe; writes complete silently in the grant cycle.
  always_comb begin
    rvalid_d = '0;
    if (gnt_any && !gnt_we) begin
      rvalid_d = grant;
    end
  end

  // Pointer and read-strobe registers; reset drops any in-flight strobe.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ptr_q    <= '0;
      rvalid_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.req_ready   = grant;
  assign bus.ram_en      = gnt_any;
  assign bus.ram_we      = gnt_we;
  assign bus.resp_rvalid = rvalid_q;
  // The RAM only updates dout on reads, so this is the owner's data whenever
  // a strobe is high and simply the last read value otherwise.
  assign bus.resp_rdata  = bus.ram_dout;

endmodule

// File: tb/tb_iob_ram_sp_arb.sv
// Bench for iob_ram_sp_arb with N_REQ=2: behavioural RAM, a reference
// memory plus round-robin model, and a queue of expected read strobes
// checked every cycle against resp_rvalid/resp_rdata.
module tb_iob_ram_sp_arb;

  localparam int N_REQ  = 2;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct {
    int         due;
    logic [1:0] owner;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic arst_n;
  int   cyc;
  int   errors;
  int   checks;
  logic m_ptr;

  logic [7:0] mem     [0:DEPTH-1];
  logic [7:0] ref_mem [0:DEPTH-1];
  exp_t       sb_q [$];
  exp_t       sb_e;

  iob_ram_sp_arb_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  iob_ram_sp_arb #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // single-port RAM: write or registered read, dout only changes on reads
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] = bus.ram_din;
      else            bus.ram_dout <= mem[bus.ram_addr];
    end
  end

  // scoreboard: every cycle the strobe is either the due entry or zero
  always @(posedge clk) begin
    #3;
    while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
      sb_e = sb_q.pop_front();
      checks++;
      errors++;
      $display("FAIL sb_missed: strobe owner %b due cycle %0d never checked", sb_e.owner, sb_e.due);
    end
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      sb_e = sb_q.pop_front();
      checks++;
      if (bus.resp_rvalid !== sb_e.owner || bus.resp_rdata !== sb_e.data) begin
        errors++;
        $display("FAIL sb_resp cyc %0d: got rvalid=%b rdata=%h expected rvalid=%b rdata=%h",
                 cyc, bus.resp_rvalid, bus.resp_rdata, sb_e.owner, sb_e.data);
      end
    end else begin
      checks++;
      if (bus.resp_rvalid !== 2'b00) begin
        errors++;
        $display("FAIL sb_idle cyc %0d: got rvalid=%b expected 00", cyc, bus.resp_rvalid);
      end
    end
  end

  // One bus cycle: drive at posedge+1, sample combinational outputs at negedge,
  // advance the reference model as if the posedge just happened.
  task automatic drive_cycle(input logic [1:0] v, input logic [1:0] we,
                             input logic [13:0] a0, input logic [13:0] a1,
                             input logic [7:0] d0, input logic [7:0] d1,
                             output logic [1:0] obs_rdy, output logic obs_en,
                             output logic obs_we, output logic [13:0] obs_addr,
                             output logic [1:0] exp_rdy);
    logic [13:0] a_k;
    logic [7:0]  d_k;
    logic        w_k;
    @(posedge clk);
    #1;
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = {a1, a0};
    bus.req_wdata = {d1, d0};
    @(negedge clk);
    obs_rdy  = bus.req_ready;
    obs_en   = bus.ram_en;
    obs_we   = bus.ram_we;
    obs_addr = bus.ram_addr;
    if (v == 2'b11) exp_rdy = m_ptr ? 2'b10 : 2'b01;
    else            exp_rdy = v;
    if (exp_rdy != 2'b00) begin
      a_k = exp_rdy[1] ? a1 : a0;
      d_k = exp_rdy[1] ? d1 : d0;
      w_k = exp_rdy[1] ? we[1] : we[0];
      if (w_k) ref_mem[a_k] = d_k;
      else     sb_q.push_back('{cyc + 1, exp_rdy, ref_mem[a_k]});
      m_ptr = ~exp_rdy[1];
    end
  endtask

  task automatic idle_cycle(output logic obs_en);
    logic [1:0]  r;
    logic [1:0]  e;
    logic        w;
    logic [13:0] a;
    drive_cycle(2'b00, 2'b00, 14'h0, 14'h0, 8'h0, 8'h0, r, obs_en, w, a, e);
  endtask

  task automatic test_reset();
    logic [1:0]  r;
    logic [1:0]  e;
    logic        en;
    logic        w;
    logic [13:0] a;
    bus.req_valid = 2'b11;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.resp_rvalid !== 2'b00) begin
      errors++;
      $display("FAIL reset_rvalid: got %b expected 00", bus.resp_rvalid);
    end
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 01", bus.req_ready);
    end
    bus.req_valid = 2'b00;
    arst_n = 1'b1;
    m_ptr  = 1'b0;
    drive_cycle(2'b11, 2'b00, 14'h1, 14'h2, 8'h0, 8'h0, r, en, w, a, e);
    checks++;
    if (r !== 2'b01) begin
      errors++;
      $display("FAIL reset_first_grant: got %b expected 01", r);
    end
    idle_cycle(en);
    idle_cycle(en);
  endtask

  task automatic test_single_read();
    logic [1:0]  r;
    logic [1:0]  e;
    logic        en;
    logic        w;
    logic [13:0] a;
    mem[14'h10]     = 8'hA5;
    ref_mem[14'h10] = 8'hA5;
    drive_cycle(2'b01, 2'b00, 14'h10, 14'h0, 8'h0, 8'h0, r, en, w, a, e);
    checks++;
    if (r !== 2'b01 || en !== 1'b1 || w !== 1'b0 || a !== 14'h10) begin
      errors++;
      $display("FAIL single_drive: got rdy=%b en=%b we=%b addr=%h expected 01 1 0 0010", r, en, w, a);
    end
    idle_cycle(en);
    checks++;
    if (bus.resp_rvalid !== 2'b01 || bus.resp_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL single_resp: got rvalid=%b rdata=%h expected 01 a5", bus.resp_rvalid, bus.resp_rdata);
    end
    idle_cycle(en);
    checks++;
    if (bus.resp_rvalid !== 2'b00) begin
      errors++;
      $display("FAIL single_strobe_low: got %b expected 00", bus.resp_rvalid);
    end
  endtask

  task automatic test_contention();
    logic [1:0]  r;
    logic [1:0]  e;
    logic [1:0]  want;
    logic        en;
    logic        w;
    logic [13:0] a;
    // a lone req1 read leaves the pointer at 0 so contention starts with req0
    drive_cycle(2'b10, 2'b00, 14'h0, 14'h30, 8'h0, 8'h0, r, en, w, a, e);
    for (int i = 0; i < 6; i++) begin
      drive_cycle(2'b11, 2'b00, 14'(14'h40 + i), 14'(14'h50 + i), 8'h0, 8'h0, r, en, w, a, e);
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (r !== want || r !== e) begin
        errors++;
        $display("FAIL contention_grant %0d: got %b expected %b", i, r, want);
      end
    end
    idle_cycle(en);
    idle_cycle(en);
  endtask

  task automatic test_write_read();
    logic [1:0]  r;
    logic [1:0]  e;
    logic        en;
    logic        w;
    logic [13:0] a;
    drive_cycle(2'b10, 2'b10, 14'h0, 14'h20, 8'h0, 8'h3C, r, en, w, a, e);
    checks++;
    if (r !== 2'b10 || en !== 1'b1 || w !== 1'b1 || a !== 14'h20) begin
      errors++;
      $display("FAIL wr_drive: got rdy=%b en=%b we=%b addr=%h expected 10 1 1 0020", r, en, w, a);
    end
    drive_cycle(2'b01, 2'b00, 14'h20, 14'h0, 8'h0, 8'h0, r, en, w, a, e);
    checks++;
    if (r !== 2'b01 || w !== 1'b0 || bus.resp_rvalid !== 2'b00) begin
      errors++;
      $display("FAIL rd_after_wr_drive: got rdy=%b we=%b rvalid=%b expected 01 0 00", r, w, bus.resp_rvalid);
    end
    idle_cycle(en);
    checks++;
    if (bus.resp_rvalid !== 2'b01 || bus.resp_rdata !== 8'h3C) begin
      errors++;
      $display("FAIL rd_after_wr_resp: got rvalid=%b rdata=%h expected 01 3c", bus.resp_rvalid, bus.resp_rdata);
    end
    idle_cycle(en);
  endtask

  task automatic test_idle_gaps();
    logic [1:0]  r;
    logic [1:0]  e;
    logic        en;
    logic        w;
    logic [13:0] a;
    drive_cycle(2'b10, 2'b00, 14'h0, 14'h77, 8'h0, 8'h0, r, en, w, a, e);
    checks++;
    if (r !== 2'b10) begin
      errors++;
      $display("FAIL idle_single_grant: got %b expected 10", r);
    end
    for (int i = 0; i < 3; i++) begin
      idle_cycle(en);
      checks++;
      if (en !== 1'b0) begin
        errors++;
        $display("FAIL idle_ram_en %0d: got %b expected 0", i, en);
      end
    end
    drive_cycle(2'b11, 2'b00, 14'h78, 14'h79, 8'h0, 8'h0, r, en, w, a, e);
    checks++;
    if (r !== 2'b01) begin
      errors++;
      $display("FAIL idle_then_both: got %b expected 01", r);
    end
    idle_cycle(en);
    idle_cycle(en);
  endtask

  task automatic test_reset_mid_read();
    logic [1:0]  r;
    logic [1:0]  e;
    logic        en;
    logic        w;
    logic [13:0] a;
    // pointer is 1 here (last grant went to req0)
    @(posedge clk);
    #1;
    bus.req_valid = 2'b10;
    bus.req_we    = 2'b00;
    bus.req_addr  = {14'h55, 14'h0};
    #1;
    arst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.resp_rvalid !== 2'b00 || bus.req_ready !== 2'b10) begin
      errors++;
      $display("FAIL midrst_grant_cycle: got rvalid=%b rdy=%b expected 00 10", bus.resp_rvalid, bus.req_ready);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (bus.resp_rvalid !== 2'b00) begin
      errors++;
      $display("FAIL midrst_no_strobe: got %b expected 00", bus.resp_rvalid);
    end
    arst_n = 1'b1;
    m_ptr  = 1'b0;
    sb_q.delete();
    drive_cycle(2'b11, 2'b00, 14'h60, 14'h61, 8'h0, 8'h0, r, en, w, a, e);
    checks++;
    if (r !== 2'b01) begin
      errors++;
      $display("FAIL midrst_ptr_zero: got %b expected 01", r);
    end
    idle_cycle(en);
    checks++;
    if (bus.resp_rvalid !== 2'b01 || bus.resp_rdata !== ref_mem[14'h60]) begin
      errors++;
      $display("FAIL midrst_read: got rvalid=%b rdata=%h expected 01 %h",
               bus.resp_rvalid, bus.resp_rdata, ref_mem[14'h60]);
    end
    idle_cycle(en);
  endtask

  initial begin
    arst_n        = 1'b0;
    cyc           = 0;
    errors        = 0;
    checks        = 0;
    m_ptr         = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_we    = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 8'(i * 37 + 11);
      ref_mem[i] = 8'(i * 37 + 11);
    end
    test_reset();
    test_single_read();
    test_contention();
    test_write_read();
    test_idle_gaps();
    test_reset_mid_read();
    idle_cycle(sb_e.owner[0]);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending strobes expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
